// File: rtl/fht_unload.sv
// fht_unload: streams a finished 4-bank FHT result out as points n=0..N-1.
// Ports: iCLK/iRESET (sync, active-low); iFHT_RDY rising edge starts an unload;
//   iBANK_0..3 read data (1-cycle latency) for shared address oADDR_RD;
//   oDATA/oINDEX/oLAST qualified by oVALID, accepted by iREADY;
//   oBUSY while unloading; oDONE one-cycle pulse after the last point.
module fht_unload #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 8
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iFHT_RDY,
  input  logic signed [D_BIT-1:0] iBANK_0,
  input  logic signed [D_BIT-1:0] iBANK_1,
  input  logic signed [D_BIT-1:0] iBANK_2,
  input  logic signed [D_BIT-1:0] iBANK_3,
  output logic [A_BIT-1:0]        oADDR_RD,
  output logic signed [D_BIT-1:0] oDATA,
  output logic [A_BIT+1:0]        oINDEX,
  output logic                    oVALID,
  input  logic                    iREADY,
  output logic                    oLAST,
  output logic                    oBUSY,
  output logic                    oDONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STREAM,
    S_FIN
  } state_t;

  state_t state, state_n;

  logic                        rdy_q;
  logic                        armed;
  logic [A_BIT-1:0]            addr_q, addr_n;
  logic [A_BIT+1:0]            idx_q, idx_n;
  logic                        valid_q, valid_n;
  logic [3:0][D_BIT-1:0]       pts_q, pts_n;
  logic [3:0][D_BIT-1:0]       banks;

  logic start;
  logic xfer;
  logic last_pt;
  logic word_end;

  assign banks = {iBANK_3, iBANK_2, iBANK_1, iBANK_0};

  // armed blocks a level that was already high across reset release
  // from being mistaken for a fresh rising edge.
  assign start    = armed & iFHT_RDY & ~rdy_q;
  assign xfer     = valid_q & iREADY;
  assign last_pt  = &idx_q;
  assign word_end = &idx_q[1:0];

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    pts_n   = pts_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ISSUE;
          addr_n  = '0;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // Word 0 is on the bank outputs now; start prefetching word 1.
        state_n = S_STREAM;
        pts_n   = banks;
        addr_n  = addr_q + 1'b1;
        idx_n   = '0;
        valid_n = 1'b1;
      end
      S_STREAM: begin
        if (xfer) begin
          idx_n = idx_q + 1'b1;
          if (last_pt) begin
            state_n = S_FIN;
            valid_n = 1'b0;
            addr_n  = '0;
          end else if (word_end) begin
            // Address only moves here, so bank data stays stable
            // for as long as the sink stalls.
            pts_n  = banks;
            addr_n = addr_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state   <= S_IDLE;
      rdy_q   <= 1'b0;
      armed   <= ~iFHT_RDY;
      addr_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      pts_q   <= '0;
    end else begin
      state   <= state_n;
      rdy_q   <= iFHT_RDY;
      armed   <= armed | ~iFHT_RDY;
      addr_q  <= addr_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      pts_q   <= pts_n;
    end
  end

  assign oADDR_RD = addr_q;
  assign oDATA    = pts_q[idx_q[1:0]];
  assign oINDEX   = idx_q;
  assign oVALID   = valid_q;
  assign oLAST    = valid_q & last_pt;
  assign oBUSY    = (state != S_IDLE);
  assign oDONE    = (state == S_FIN);

endmodule

// File: tb/tb_fht_unload.sv
// tb_fht_unload: table of unload scenarios checked against a point-list model.
// Bank RAMs are modelled as one flat array indexed by point number.
module tb_fht_unload;

  localparam int D = 17;
  localparam int A = 8;
  localparam int N = 4 * (1 << A);

  logic                clk;
  logic                rst_n;
  logic                fht_rdy;
  logic signed [D-1:0] bank [4];
  logic [A-1:0]        addr;
  logic signed [D-1:0] data;
  logic [A+1:0]        index;
  logic                valid;
  logic                ready;
  logic                last;
  logic                busy;
  logic                done;

  logic signed [D-1:0] mem [N];

  int n_chk;
  int n_fail;

  fht_unload #(.D_BIT(D), .A_BIT(A)) dut (
    .iCLK     (clk),
    .iRESET   (rst_n),
    .iFHT_RDY (fht_rdy),
    .iBANK_0  (bank[0]),
    .iBANK_1  (bank[1]),
    .iBANK_2  (bank[2]),
    .iBANK_3  (bank[3]),
    .oADDR_RD (addr),
    .oDATA    (data),
    .oINDEX   (index),
    .oVALID   (valid),
    .iREADY   (ready),
    .oLAST    (last),
    .oBUSY    (busy),
    .oDONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered bank reads: bank b at address a holds point 4a+b.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) bank[b] <= mem[4 * int'(addr) + b];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"},  last,  0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_addr"},  addr,  0);
    chk({tag, "_index"}, index, 0);
    chk({tag, "_data"},  data,  0);
  endtask

  typedef struct {
    int mode;      // 0: ready always high, 1: random ready
    int stall_n;   // point to hold ready low on (-1 none)
    int stall_len;
    int reedge_n;  // point at which a second rdy edge is sent (-1 none)
    int rst_at;    // point at which reset is asserted (-1 none)
    int kind;      // 0: ramp data, 1: random signed data
    int exp_pts;   // transfers expected
    int exp_done;  // oDONE pulses expected
  } vec_t;

  task automatic fill_mem(input int kind);
    for (int i = 0; i < N; i++) begin
      if (kind == 0) mem[i] = D'(i);
      else           mem[i] = D'($urandom);
    end
    if (kind == 1) begin
      mem[0]    = -17'sd65536;
      mem[1]    = -17'sd1;
      mem[3]    = 17'sd65535;
      mem[4]    = -17'sd1;
      mem[N-1]  = -17'sd65536;
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int                  n;
    int                  cyc;
    int                  stalls;
    int                  dones;
    bit                  hold;
    bit                  rd;
    bit                  reedged;
    bit                  aborted;
    logic signed [D-1:0] s_data;
    logic [A+1:0]        s_index;
    logic [A-1:0]        s_addr;
    logic                s_last;
    n = 0; cyc = 0; stalls = 0; dones = 0;
    hold = 0; reedged = 0; aborted = 0;
    s_data = '0; s_index = '0; s_addr = '0; s_last = 0;
    fill_mem(v.kind);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    fht_rdy = 1'b1;
    ready   = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      fht_rdy = 1'b0;
      chk("lat_busy", busy, 1);
      chk("lat_valid", valid, c == 3);
    end
    while (n < N && !aborted) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      fht_rdy = 1'b0;
      if (cyc > 20000) begin
        chk("stream_timeout", n, N);
        break;
      end
      if (done) dones++;
      chk("stream_valid", valid, 1);
      chk("stream_busy", busy, 1);
      if (hold) begin
        chk("hold_data",  data,  s_data);
        chk("hold_index", index, s_index);
        chk("hold_last",  last,  s_last);
        chk("hold_addr",  addr,  s_addr);
      end
      chk("index", index, n);
      chk("data",  data,  mem[n]);
      chk("last",  last,  n == N - 1);
      chk("addr",  addr,  ((n / 4) + 1) % (1 << A));
      if (n == v.rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst_n   = 1'b1;
        aborted = 1;
        break;
      end
      if (n == v.reedge_n && !reedged) begin
        fht_rdy = 1'b1;
        reedged = 1;
      end
      rd = (v.mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (n == v.stall_n && stalls < v.stall_len) begin
        rd = 1'b0;
        stalls++;
      end
      ready   = rd;
      hold    = !rd;
      s_data  = data;
      s_index = index;
      s_addr  = addr;
      s_last  = last;
      if (rd) n++;
    end
    if (!aborted && n == N) begin
      @(negedge clk);
      fht_rdy = 1'b0;
      if (done) dones++;
      chk("fin_valid", valid, 0);
      chk("fin_done",  done,  1);
      chk("fin_busy",  busy,  1);
      chk("fin_addr",  addr,  0);
      chk("fin_index", index, 0);
      @(negedge clk);
      chk("post_busy", busy, 0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dones++;
      chk("quiet_busy", busy, 0);
    end
    chk("transfers", n, v.exp_pts);
    chk("done_count", dones, v.exp_done);
    if (n_fail != 0) $display("vector %0d done, failures so far %0d", id, n_fail);
  endtask

  vec_t vecs [7];

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    fht_rdy = 1'b0;
    ready   = 1'b0;
    fill_mem(0);

    vecs[0] = '{mode:0, stall_n:-1,   stall_len:0,  reedge_n:-1,  rst_at:-1,
                kind:0, exp_pts:N,    exp_done:1};
    vecs[1] = '{mode:1, stall_n:-1,   stall_len:0,  reedge_n:-1,  rst_at:-1,
                kind:0, exp_pts:N,    exp_done:1};
    vecs[2] = '{mode:0, stall_n:3,    stall_len:20, reedge_n:-1,  rst_at:-1,
                kind:0, exp_pts:N,    exp_done:1};
    vecs[3] = '{mode:1, stall_n:-1,   stall_len:0,  reedge_n:500, rst_at:-1,
                kind:0, exp_pts:N,    exp_done:1};
    vecs[4] = '{mode:0, stall_n:-1,   stall_len:0,  reedge_n:-1,  rst_at:600,
                kind:0, exp_pts:600,  exp_done:0};
    vecs[5] = '{mode:1, stall_n:N-1,  stall_len:5,  reedge_n:-1,  rst_at:-1,
                kind:1, exp_pts:N,    exp_done:1};
    vecs[6] = '{mode:0, stall_n:4,    stall_len:3,  reedge_n:-1,  rst_at:-1,
                kind:1, exp_pts:N,    exp_done:1};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(vecs[i], i);

    // A level already high when reset releases must not start an unload.
    @(negedge clk);
    fht_rdy = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("lvl_rst");
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lvl_busy",  busy,  0);
      chk("lvl_valid", valid, 0);
    end
    fht_rdy = 1'b0;
    @(negedge clk);
    run(vecs[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
